// File: rtl/mux82_pkg.sv
// mux82_pkg
//   Shared constants and types for the registered 8-to-1 lane selector.
//   NUM_IN : number of input lanes (fixed at 8)
//   SEL_W  : select width, clog2(NUM_IN)
//   sel_t  : lane select type
//   lane_of: reference lane extraction used by the bench scoreboard. It works
//            on a generously sized vector so one function covers every lane
//            width up to 32 bits.
package mux82_pkg;

  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Returns lane s of d, where each lane is lane_w bits and lane 0 sits in
  // the LSBs. Bits above lane_w in the result are zero.
  function automatic logic [31:0] lane_of(input logic [NUM_IN*32-1:0] d,
                                          input sel_t                 s,
                                          input int                   lane_w);
    logic [31:0] r_lane;
    r_lane = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < lane_w) begin
        r_lane[i] = d[int'(s) * lane_w + i];
      end
    end
    return r_lane;
  endfunction

endpackage

// File: rtl/mux82_core.sv
// mux82_core
//   Purely combinational LANE_W-wide 8:1 lane selector.
//   d   : input, NUM_IN*LANE_W packed lanes, lane 0 in the LSBs
//   s   : input, lane select (unsigned)
//   sel : output, the selected lane
module mux82_core
  import mux82_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic [NUM_IN*LANE_W-1:0] d,
  input  sel_t                     s,
  output logic [LANE_W-1:0]        sel
);

  // Every one of the eight codes names a lane, so the case is complete and
  // the leading default only exists to keep the block obviously latch-free.
  always_comb begin
    sel = '0;
    case (s)
      3'd0: sel = d[0*LANE_W +: LANE_W];
      3'd1: sel = d[1*LANE_W +: LANE_W];
      3'd2: sel = d[2*LANE_W +: LANE_W];
      3'd3: sel = d[3*LANE_W +: LANE_W];
      3'd4: sel = d[4*LANE_W +: LANE_W];
      3'd5: sel = d[5*LANE_W +: LANE_W];
      3'd6: sel = d[6*LANE_W +: LANE_W];
      3'd7: sel = d[7*LANE_W +: LANE_W];
    endcase
  end

endmodule

// File: rtl/mux82.sv
// mux82
//   Registered 8-to-1 lane selector with a one-cycle latency.
//   clk       : input, rising-edge clock
//   rst_n     : input, asynchronous active-low reset
//   d         : input, NUM_IN*LANE_W packed lanes, lane 0 in the LSBs
//   s         : input, lane select
//   in_valid  : input, qualifies d and s this cycle
//   y         : output, selected lane, registered
//   out_valid : output, y was captured from a valid input on the last edge
module mux82
  import mux82_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*LANE_W-1:0] d,
  input  sel_t                     s,
  input  logic                     in_valid,
  output logic [LANE_W-1:0]        y,
  output logic                     out_valid
);

  logic [LANE_W-1:0] w_sel;
  logic [LANE_W-1:0] r_y;
  logic              r_out_valid;

  mux82_core #(
    .LANE_W (LANE_W)
  ) u_core (
    .d   (d),
    .s   (s),
    .sel (w_sel)
  );

  // y only moves on a valid input; out_valid is a one-cycle pulse per
  // captured input so idle cycles read as "nothing new".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_y <= w_sel;
      end
    end
  end

  assign y         = r_y;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux82.sv
// tb_mux82
//   Directed bench for mux82: one instance with 1-bit lanes and one with
//   4-bit lanes. Inputs change 1 time unit after a rising edge and outputs
//   are sampled at that same point, i.e. they reflect the previous edge.
module tb_mux82;
  import mux82_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  d;
  sel_t        s;
  logic        in_valid;
  logic [0:0]  y;
  logic        out_valid;

  logic        rst_wn;
  logic [31:0] d_w;
  sel_t        s_w;
  logic        in_valid_w;
  logic [3:0]  y_w;
  logic        out_valid_w;

  int n_cmp;
  int n_bad;

  mux82 #(.LANE_W(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .s         (s),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid)
  );

  mux82 #(.LANE_W(4)) u_dut_w (
    .clk       (clk),
    .rst_n     (rst_wn),
    .d         (d_w),
    .s         (s_w),
    .in_valid  (in_valid_w),
    .y         (y_w),
    .out_valid (out_valid_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    rst_wn     = 1'b0;
    d          = '0;
    s          = '0;
    in_valid   = 1'b0;
    d_w        = '0;
    s_w        = '0;
    in_valid_w = 1'b0;

    // Reset state
    #2;
    check("reset_y", 32'(y), 32'h0);
    check("reset_ov", 32'(out_valid), 32'h0);
    check("reset_y_w", 32'(y_w), 32'h0);
    step();
    step();
    rst_n  = 1'b1;
    rst_wn = 1'b1;

    // First valid input after reset release lands one cycle later.
    d = 8'h01; s = 3'd0; in_valid = 1'b1;
    step();
    check("post_rst_y", 32'(y), 32'h1);
    check("post_rst_ov", 32'(out_valid), 32'h1);

    // Asynchronous reset mid-cycle with y=1: clears before the next edge.
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("async_rst_y", 32'(y), 32'h0);
    check("async_rst_ov", 32'(out_valid), 32'h0);
    step();
    rst_n = 1'b1;

    // Walking one with matching select
    for (int i = 0; i < 8; i++) begin
      d = 8'h01 << i; s = sel_t'(i); in_valid = 1'b1;
      step();
      check($sformatf("walk%0d_y", i), 32'(y), 32'h1);
      check($sformatf("walk%0d_ov", i), 32'(out_valid), 32'h1);
    end

    // Mismatched select
    d = 8'h01; s = 3'd1;
    step();
    check("mis_01_s1", 32'(y), 32'h0);
    d = 8'hFE; s = 3'd0;
    step();
    check("mis_fe_s0", 32'(y), 32'h0);
    d = 8'hFE; s = 3'd7;
    step();
    check("mis_fe_s7", 32'(y), 32'h1);

    // Hold with y=1 while invalid and the selected bit is 0
    d = 8'h00; s = 3'd7; in_valid = 1'b0;
    step();
    check("hold1_y", 32'(y), 32'h1);
    check("hold1_ov", 32'(out_valid), 32'h0);

    // Exhaustive sweep against the reference
    in_valid = 1'b1;
    for (int dv = 0; dv < 256; dv++) begin
      for (int sv = 0; sv < 8; sv++) begin
        d = 8'(dv); s = sel_t'(sv);
        step();
        check($sformatf("sweep_d%02h_s%0d", dv, sv), 32'(y),
              lane_of({248'b0, 8'(dv)}, sel_t'(sv), 1));
        check($sformatf("sweep_ov_d%02h_s%0d", dv, sv), 32'(out_valid), 32'h1);
      end
    end

    // Valid gating: capture y=0, then invalid d=FF,s=3
    d = 8'h00; s = 3'd0;
    step();
    check("gate_pre_y", 32'(y), 32'h0);
    d = 8'hFF; s = 3'd3; in_valid = 1'b0;
    step();
    check("gate_y", 32'(y), 32'h0);
    check("gate_ov", 32'(out_valid), 32'h0);
    step();
    check("gate_y2", 32'(y), 32'h0);
    in_valid = 1'b1;
    step();
    check("gate_rise_y", 32'(y), 32'h1);
    check("gate_rise_ov", 32'(out_valid), 32'h1);
    in_valid = 1'b0;

    // Wide lanes: each code returns its own lane index
    d_w = 32'h76543210; s_w = 3'd5; in_valid_w = 1'b1;
    step();
    check("wide_s5", 32'(y_w), 32'h5);
    check("wide_s5_ov", 32'(out_valid_w), 32'h1);
    d_w = 32'hFEDCBA98;
    for (int i = 0; i < 8; i++) begin
      s_w = sel_t'(i);
      step();
      check($sformatf("wide_fe_s%0d", i), 32'(y_w), 32'(8 + i));
    end

    // Reset in the same cycle as a valid input: the capture is lost.
    d_w = 32'h76543210; s_w = 3'd5; in_valid_w = 1'b1;
    rst_wn = 1'b0;
    step();
    check("wide_rst_y", 32'(y_w), 32'h0);
    check("wide_rst_ov", 32'(out_valid_w), 32'h0);
    rst_wn = 1'b1;
    s_w = 3'd2;
    step();
    check("wide_after_y", 32'(y_w), 32'h2);
    check("wide_after_ov", 32'(out_valid_w), 32'h1);
    in_valid_w = 1'b0;
    step();
    check("wide_idle_ov", 32'(out_valid_w), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
